// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared types, constants and helpers for the LFSR stream cipher
//
// Purpose : FSM state encoding, ASCII offset, catalogue of 7-bit maximal-length
//           LFSR tap masks and a parity helper used by the cipher top.
// Ports   : none (package).
package cipher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_MSG,
    ST_PAD,
    ST_DONE
  } state_e;

  localparam int ASCII_OFFSET = 'h20;

  // Maximal-length feedback masks for a 7-bit register shifting left.
  localparam logic [6:0] MAX_TAPS_7 [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Callers zero-extend narrower vectors; that never changes the parity.
  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - runtime-configurable Fibonacci LFSR register
//
// Purpose : W-bit LFSR. load_i takes priority and copies seed_i; otherwise
//           step_i advances one step: next = {s[W-2:0], ^(s & taps_i)}.
// Ports   : clk_i, rst_ni (async active-low), load_i, seed_i[W-1:0],
//           taps_i[W-1:0], step_i, state_o[W-1:0].
module lfsr_core #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic [W-1:0] taps_i,
  input  logic         step_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = {state_q[W-2:0], ^(state_q & taps_i)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_stream_cipher.sv
// rtl/lfsr_stream_cipher.sv - framed LFSR stream cipher (encrypt / decrypt) co-processor
//
// Purpose : Builds a FRAME_LEN-byte frame: space preamble, message, space padding.
//           Encrypt: x = (c - 0x20) ^ lfsr, out = {^x, x}. Decrypt: x = in ^ lfsr,
//           out = {0, x + 0x20}, with parity check of the incoming byte.
// Ports   : clk_i, rst_ni (async active-low); Start, cfg_mode, cfg_taps, cfg_seed,
//           cfg_pre (run config); in_valid/in_data/in_last/in_ready (input stream);
//           out_valid/out_data/out_ready (output stream, one-entry register);
//           Ack (run complete), err_parity, err_range (sticky per run).
module lfsr_stream_cipher
  import cipher_pkg::*;
#(
  parameter  int W         = 7,
  parameter  int FRAME_LEN = 64,
  parameter  int PRE_MIN   = 10,
  parameter  int PRE_MAX   = 15,
  localparam int PRE_W     = $clog2(PRE_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             Start,
  input  logic             cfg_mode,
  input  logic [W-1:0]     cfg_taps,
  input  logic [W-1:0]     cfg_seed,
  input  logic [PRE_W-1:0] cfg_pre,
  input  logic             in_valid,
  input  logic [W:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W:0]       out_data,
  input  logic             out_ready,
  output logic             Ack,
  output logic             err_parity,
  output logic             err_range
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     taps_q, taps_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             out_valid_q, out_valid_d;
  logic [W:0]       out_data_q, out_data_d;
  logic             err_par_q, err_par_d;
  logic             err_rng_q, err_rng_d;

  logic             lfsr_load, lfsr_step;
  logic [W-1:0]     lfsr_seed, lfsr_s;
  logic             can_emit;
  logic [W-1:0]     enc_p, enc_x, dec_x;
  logic [W:0]       enc_byte;

  function automatic logic [PRE_W-1:0] clamp_pre(input logic [PRE_W-1:0] v);
    if (int'(v) < PRE_MIN) return PRE_W'(PRE_MIN);
    if (int'(v) > PRE_MAX) return PRE_W'(PRE_MAX);
    return v;
  endfunction

  lfsr_core #(.W(W)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (lfsr_load),
    .seed_i (lfsr_seed),
    .taps_i (taps_q),
    .step_i (lfsr_step),
    .state_o(lfsr_s)
  );

  // The output register may take a new byte when empty or being drained this cycle.
  assign can_emit  = !out_valid_q || out_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  assign lfsr_seed = (cfg_seed == '0) ? W'(1) : cfg_seed;

  // Preamble and padding carry a space, i.e. payload 0.
  assign enc_p    = (state_q == ST_MSG) ? (in_data[W-1:0] - W'(ASCII_OFFSET)) : '0;
  assign enc_x    = enc_p ^ lfsr_s;
  assign enc_byte = {parity(32'(enc_x)), enc_x};
  assign dec_x    = in_data[W-1:0] ^ lfsr_s;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    taps_d      = taps_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    err_par_d   = err_par_q;
    err_rng_d   = err_rng_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    in_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d   = cfg_mode ? ST_MSG : ST_PRE;
          mode_d    = cfg_mode;
          taps_d    = cfg_taps;
          pre_d     = clamp_pre(cfg_pre);
          cnt_d     = '0;
          err_par_d = 1'b0;
          err_rng_d = 1'b0;
          lfsr_load = 1'b1;
        end
      end

      ST_PRE: begin
        if (can_emit) begin
          out_valid_d = 1'b1;
          out_data_d  = enc_byte;
          lfsr_step   = 1'b1;
          cnt_d       = cnt_inc;
          if (cnt_inc == CNT_W'(pre_q)) state_d = ST_MSG;
        end
      end

      ST_MSG: begin
        in_ready = can_emit;
        if (can_emit && in_valid) begin
          out_valid_d = 1'b1;
          lfsr_step   = 1'b1;
          cnt_d       = cnt_inc;
          if (mode_q) begin
            out_data_d = {1'b0, dec_x + W'(ASCII_OFFSET)};
            if (in_data[W] != parity(32'(in_data[W-1:0]))) err_par_d = 1'b1;
          end else begin
            out_data_d = enc_byte;
            if (in_data < (W+1)'(ASCII_OFFSET) ||
                in_data > (W+1)'(ASCII_OFFSET + (2 ** W) - 1)) err_rng_d = 1'b1;
            if (in_last) state_d = ST_PAD;
          end
          if (cnt_inc == CNT_W'(FRAME_LEN)) state_d = ST_PAD;
        end
      end

      ST_PAD: begin
        // With the frame full, DONE waits until the final byte has left the register.
        if (cnt_q == CNT_W'(FRAME_LEN)) begin
          if (can_emit) state_d = ST_DONE;
        end else if (can_emit) begin
          out_valid_d = 1'b1;
          out_data_d  = enc_byte;
          lfsr_step   = 1'b1;
          cnt_d       = cnt_inc;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      taps_q      <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_par_q   <= 1'b0;
      err_rng_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      taps_q      <= taps_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_par_q   <= err_par_d;
      err_rng_q   <= err_rng_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign Ack        = (state_q == ST_DONE);
  assign err_parity = err_par_q;
  assign err_range  = err_rng_q;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// tb/tb_lfsr_stream_cipher.sv - self-checking bench for lfsr_stream_cipher
module tb_lfsr_stream_cipher;
  import cipher_pkg::*;

  localparam int FRAME_LEN = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cfg_mode;
  logic [6:0] cfg_taps, cfg_seed;
  logic [3:0] cfg_pre;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       ack, err_parity, err_range;

  always #5 clk = ~clk;

  lfsr_stream_cipher dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .Start     (start),
    .cfg_mode  (cfg_mode),
    .cfg_taps  (cfg_taps),
    .cfg_seed  (cfg_seed),
    .cfg_pre   (cfg_pre),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .Ack       (ack),
    .err_parity(err_parity),
    .err_range (err_range)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] msg_q[$];
  logic [7:0] cipher[FRAME_LEN];
  int         n_acc = 0;
  bit         ack_pending = 0;
  bit         stall_prev = 0;
  logic [7:0] held;
  int         exp_consumed;
  bit         exp_erange, exp_eparity;
  int         last_iters, last_consumed;
  bit         aborted;
  string      watson = "Mr. Watson, come here. I want to see you.";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return 32'(got_q[i]);
    return 32'h100;
  endfunction

  function automatic int lfsr_next(input int s, input int taps);
    int fb = $countones(s & taps) % 2;
    return ((s << 1) | fb) & 'h7F;
  endfunction

  function automatic int clamp(input int p);
    return (p < 10) ? 10 : ((p > 15) ? 15 : p);
  endfunction

  // Reference frame for encryption: preamble spaces, consumed message, padding spaces.
  task automatic model_encrypt(input int taps, input int seed, input int pre_raw);
    int s = (seed == 0) ? 1 : seed;
    int p = clamp(pre_raw);
    exp_q.delete();
    exp_erange   = 0;
    exp_consumed = (msg_q.size() < FRAME_LEN - p) ? msg_q.size() : FRAME_LEN - p;
    for (int i = 0; i < FRAME_LEN; i++) begin
      int c = (i >= p && i - p < exp_consumed) ? int'(msg_q[i-p]) : 'h20;
      int x = ((c - 'h20) & 'h7F) ^ s;
      cipher[i] = 8'(($countones(x) % 2) * 128 + x);
      exp_q.push_back(cipher[i]);
      if (c < 'h20 || c > 'h9F) exp_erange = 1;
      s = lfsr_next(s, taps);
    end
  endtask

  task automatic model_decrypt(input int taps, input int seed);
    int s = (seed == 0) ? 1 : seed;
    exp_q.delete();
    exp_eparity  = 0;
    exp_consumed = FRAME_LEN;
    for (int i = 0; i < FRAME_LEN; i++) begin
      int b = int'(cipher[i]);
      int x = (b & 'h7F) ^ s;
      exp_q.push_back(8'((x + 'h20) & 'h7F));
      if (((b >> 7) & 1) != ($countones(b & 'h7F) % 2)) exp_eparity = 1;
      s = lfsr_next(s, taps);
    end
  endtask

  task automatic load_watson();
    msg_q.delete();
    for (int i = 0; i < watson.len(); i++) msg_q.push_back(8'(watson[i]));
  endtask

  task automatic load_random(input int len, input bit in_range);
    msg_q.delete();
    for (int i = 0; i < len; i++)
      msg_q.push_back(in_range ? 8'($urandom_range('h20, 'h9F)) : 8'($urandom_range('h18, 'hA8)));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev  = 0;
      ack_pending = 0;
    end else begin
      if (ack_pending) begin
        chk("ack_rise", 32'(ack), 1);
        ack_pending = 0;
      end
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        chk("ack_early", 32'(ack), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_byte: got 0x%0h, expected no byte", out_data);
        end else begin
          chk("stream", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got_q.push_back(out_data);
        n_acc++;
        if (n_acc == FRAME_LEN) ack_pending = 1;
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
    end
  end

  task automatic start_run(input bit mode, input logic [6:0] taps, input logic [6:0] seed,
                           input logic [3:0] pre);
    @(posedge clk);
    #1;
    n_acc = 0;
    got_q.delete();
    cfg_mode = mode;
    cfg_taps = taps;
    cfg_seed = seed;
    cfg_pre  = pre;
    in_valid = 0;
    start    = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err_parity"}, 32'(err_parity), 0);
    chk({tag, "_err_range"}, 32'(err_range), 0);
  endtask

  task automatic run_frame(input bit mode, input bit rnd, input int abort_at);
    int idx = 0;
    int k = 0;
    int src_n;
    bit acc = 0;
    bit done = 0;
    aborted = 0;
    while (!done) begin
      if (acc) idx++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      src_n = mode ? FRAME_LEN : msg_q.size();
      if (idx < src_n && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1;
        in_data  = mode ? cipher[idx] : msg_q[idx];
        in_last  = !mode && (idx == src_n - 1);
      end else begin
        in_valid = 0;
        in_data  = 8'($urandom);
        in_last  = 0;
      end
      @(negedge clk);
      k++;
      acc = in_valid && in_ready;
      if (ack) begin
        done = 1;
      end else if (abort_at > 0 && n_acc >= abort_at) begin
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1;
        aborted = 1;
        done    = 1;
      end else if (k > 4000) begin
        chk("ack_timeout", 32'(ack), 1);
        done = 1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    last_iters    = k;
    last_consumed = idx;
    in_valid      = 0;
    in_last       = 0;
  endtask

  task automatic finish_checks(input string tag);
    chk({tag, "_leftover"}, 32'(exp_q.size()), 0);
    chk({tag, "_bytes"}, 32'(n_acc), FRAME_LEN);
    chk({tag, "_ack"}, 32'(ack), 1);
    chk({tag, "_consumed"}, 32'(last_consumed), 32'(exp_consumed));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, len;
    logic [6:0] tp, sd;

    rst_n = 0; start = 0; cfg_mode = 0; cfg_taps = '0; cfg_seed = '0; cfg_pre = '0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1;

    // Reference frame: taps 0x7B, seed 1, preamble 13.
    load_watson();
    model_encrypt(MAX_TAPS_7[8], 1, 13);
    chk("model_b0", 32'(exp_q[0]), 'h81);
    chk("model_b1", 32'(exp_q[1]), 'h03);
    chk("model_b2", 32'(exp_q[2]), 'h06);
    start_run(0, MAX_TAPS_7[8], 7'h01, 4'd13);
    run_frame(0, 0, 0);
    finish_checks("watson");
    chk("watson_latency", 32'(last_iters - 1), FRAME_LEN + 1);
    chk("watson_b0", got_at(0), 'h81);
    chk("watson_b1", got_at(1), 'h03);
    chk("watson_b2", got_at(2), 'h06);
    chk("watson_err_range", 32'(err_range), 0);

    // Zero seed and short preamble behave as seed 1 with the minimum preamble.
    load_random(20, 1);
    model_encrypt(MAX_TAPS_7[0], 1, 10);
    start_run(0, MAX_TAPS_7[0], 7'h00, 4'd5);
    run_frame(0, 1, 0);
    finish_checks("seed0");

    // Randomized frames; trial 0 fills the frame exactly, odd trials may hit range errors.
    for (int t = 0; t < 5; t++) begin
      tp  = MAX_TAPS_7[$urandom_range(0, 8)];
      sd  = 7'($urandom_range(0, 127));
      p   = $urandom_range(0, 15);
      len = (t == 0) ? FRAME_LEN - clamp(p) : $urandom_range(1, 60);
      load_random(len, (t % 2) == 0);
      model_encrypt(int'(tp), int'(sd), p);
      start_run(0, tp, sd, 4'(p));
      run_frame(0, 1, 0);
      finish_checks("rand");
      chk("rand_err_range", 32'(err_range), 32'(exp_erange));
    end

    // Loopback: encrypt then decrypt with taps 0x48, seed 0x35.
    load_watson();
    model_encrypt(MAX_TAPS_7[1], 'h35, 13);
    start_run(0, MAX_TAPS_7[1], 7'h35, 4'd13);
    run_frame(0, 1, 0);
    finish_checks("loop_enc");
    model_decrypt(MAX_TAPS_7[1], 'h35);
    start_run(1, MAX_TAPS_7[1], 7'h35, 4'd0);
    run_frame(1, 1, 0);
    finish_checks("loop_dec");
    chk("loop_err_parity", 32'(err_parity), 0);
    for (int i = 0; i < FRAME_LEN; i++)
      chk("loop_plain", got_at(i),
          (i >= 13 && i < 13 + msg_q.size()) ? 32'(msg_q[i-13]) : 'h20);

    // Corrupt the parity bit of cipher byte 20.
    cipher[20] = cipher[20] ^ 8'h80;
    model_decrypt(MAX_TAPS_7[1], 'h35);
    start_run(1, MAX_TAPS_7[1], 7'h35, 4'd0);
    run_frame(1, 1, 0);
    finish_checks("par_dec");
    chk("par_set", 32'(err_parity), 32'(exp_eparity));
    chk("par_set_lit", 32'(err_parity), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("par_sticky", 32'(err_parity), 1);
    load_watson();
    model_encrypt(MAX_TAPS_7[8], 1, 13);
    start_run(0, MAX_TAPS_7[8], 7'h01, 4'd13);
    chk("par_clear", 32'(err_parity), 0);
    chk("start_ack_clear", 32'(ack), 0);
    run_frame(0, 1, 0);
    finish_checks("par_next");

    // Reset in mid-frame, then a clean full frame.
    model_encrypt(MAX_TAPS_7[8], 1, 13);
    start_run(0, MAX_TAPS_7[8], 7'h01, 4'd13);
    run_frame(0, 1, 30);
    chk("abort_taken", 32'(aborted), 1);
    model_encrypt(MAX_TAPS_7[8], 1, 13);
    start_run(0, MAX_TAPS_7[8], 7'h01, 4'd13);
    run_frame(0, 0, 0);
    finish_checks("after_abort");
    chk("after_abort_latency", 32'(last_iters - 1), FRAME_LEN + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
